// File: rtl/trace_capture_unit.sv
// On-chip trace buffer: samples CH channels into a circular buffer while armed,
// freezes POST_TRIG samples after a trigger, then streams the window oldest-first.
module trace_capture_unit #(
    parameter int DATA_W    = 32,
    parameter int CH        = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CH*DATA_W-1:0]       ch_data,
    input  logic                       ch_valid,
    input  logic                       arm,
    input  logic                       trigger,
    output logic [CH*DATA_W-1:0]       rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       rd_last,
    output logic [$clog2(DEPTH)-1:0]   trig_pos,
    output logic                       wrapped,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int W         = CH * DATA_W;
    localparam int POST_LAST = (POST_TRIG > 0) ? POST_TRIG - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_post_cnt;
    logic            r_wrapped;
    logic [AW-1:0]   r_trig_pos;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_fetch_left;
    logic [W-1:0]    r_rd_data;
    logic            r_rd_valid;
    logic            r_rd_last;
    logic [W-1:0]    r_mem [DEPTH];

    logic            w_wr_en;
    logic [AW-1:0]   w_wr_ptr_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic            w_enter_read;
    logic [AW-1:0]   w_start;
    logic [CW-1:0]   w_trig_full;

    assign w_wr_en      = ch_valid && ((r_state == S_ARMED) || (r_state == S_POST));
    assign w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    assign w_count_nxt  = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
    assign w_enter_read = w_wr_en &&
                          (((r_state == S_ARMED) && trigger && (POST_TRIG == 0)) ||
                           ((r_state == S_POST) && (r_post_cnt == CW'(POST_LAST))));
    // Window geometry is taken from the post-write pointers of the final sample.
    assign w_start      = (w_count_nxt == CW'(DEPTH)) ? w_wr_ptr_nxt : '0;
    assign w_trig_full  = w_count_nxt - CW'(1) - CW'(POST_TRIG);

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign trig_pos  = r_trig_pos;
    assign wrapped   = r_wrapped;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= ch_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_post_cnt   <= '0;
            r_wrapped    <= 1'b0;
            r_trig_pos   <= '0;
            r_rd_ptr     <= '0;
            r_fetch_left <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state    <= S_ARMED;
                        r_wr_ptr   <= '0;
                        r_count    <= '0;
                        r_post_cnt <= '0;
                        r_wrapped  <= 1'b0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (ch_valid) begin
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_count  <= w_count_nxt;
                        if (r_count == CW'(DEPTH)) begin
                            r_wrapped <= 1'b1;
                        end
                        if (r_state == S_POST) begin
                            r_post_cnt <= r_post_cnt + CW'(1);
                        end
                        if (w_enter_read) begin
                            r_state      <= S_READ;
                            r_rd_ptr     <= w_start;
                            r_fetch_left <= w_count_nxt;
                            r_trig_pos   <= w_trig_full[AW-1:0];
                        end else if ((r_state == S_ARMED) && trigger) begin
                            r_state <= S_POST;
                        end
                    end
                end
                S_READ: begin
                    // Output register refills whenever it is empty or being drained.
                    if (r_rd_valid && rd_ready && r_rd_last) begin
                        r_state    <= S_IDLE;
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                    end else if ((!r_rd_valid || rd_ready) && (r_fetch_left != '0)) begin
                        r_rd_data    <= r_mem[r_rd_ptr];
                        r_rd_valid   <= 1'b1;
                        r_rd_last    <= (r_fetch_left == CW'(1));
                        r_rd_ptr     <= r_rd_ptr + AW'(1);
                        r_fetch_left <= r_fetch_left - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit: capture, wrap, backpressure, qualification
// and asynchronous reset in POST and READ.
module tb_trace_capture_unit;

    localparam int DATA_W    = 32;
    localparam int CH        = 2;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 2;
    localparam int W         = CH * DATA_W;
    localparam int AW        = $clog2(DEPTH);

    logic            clk;
    logic            rst_n;
    logic [W-1:0]    ch_data;
    logic            ch_valid;
    logic            arm;
    logic            trigger;
    logic [W-1:0]    rd_data;
    logic            rd_valid;
    logic            rd_ready;
    logic            rd_last;
    logic [AW-1:0]   trig_pos;
    logic            wrapped;
    logic            busy;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    trace_capture_unit #(
        .DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
        .arm(arm), .trigger(trigger), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_last(rd_last), .trig_pos(trig_pos),
        .wrapped(wrapped), .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input int i);
        return {32'(i + 100), 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic sample(input int i, input logic trig);
        ch_data  = pk(i);
        ch_valid = 1'b1;
        trigger  = trig;
        tick();
        ch_valid = 1'b0;
        trigger  = 1'b0;
        ch_data  = '0;
    endtask

    task automatic read_window(input int first, input int n, input int stall_val);
        int waited;
        waited = 0;
        while (!rd_valid && waited < 10) begin
            tick();
            waited++;
        end
        chk("rd_valid_wait", rd_valid, 1);
        for (int k = 0; k < n; k++) begin
            chk("rd_data", rd_data, pk(first + k));
            chk("rd_valid", rd_valid, 1);
            chk("rd_last", rd_last, (k == n - 1) ? 1 : 0);
            if (first + k == stall_val) begin
                rd_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_data", rd_data, pk(first + k));
                    chk("stall_valid", rd_valid, 1);
                end
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        chk("end_valid", rd_valid, 0);
        chk("end_last", rd_last, 0);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ch_data  = '0;
        ch_valid = 1'b0;
        arm      = 1'b0;
        trigger  = 1'b0;
        rd_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_trig_pos", trig_pos, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // Short capture with qualification and backpressure on entry 3
        do_arm();
        chk("arm_busy", busy, 1);
        chk("arm_state", dbg_state, 1);
        sample(1, 1'b0);
        sample(2, 1'b0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("trig_no_valid_state", dbg_state, 1);
        sample(3, 1'b1);
        chk("post_state", dbg_state, 2);
        sample(4, 1'b1);
        chk("post_trig_ignored", dbg_state, 2);
        sample(5, 1'b0);
        chk("read_state", dbg_state, 3);
        chk("short_trig_pos", trig_pos, 2);
        chk("short_wrapped", wrapped, 0);
        chk("read_latency", rd_valid, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_in_read_state", dbg_state, 3);
        chk("first_valid", rd_valid, 1);
        read_window(1, 5, 3);
        chk("short_trig_pos_hold", trig_pos, 2);

        // Wrap: 12 samples into an 8-deep buffer
        do_arm();
        for (int i = 1; i <= 12; i++) sample(i, (i == 10) ? 1'b1 : 1'b0);
        chk("wrap_trig_pos", trig_pos, 5);
        chk("wrap_wrapped", wrapped, 1);
        read_window(5, 8, -1);
        chk("wrap_wrapped_hold", wrapped, 1);

        // Reset during READ with an entry presented
        do_arm();
        for (int i = 1; i <= 6; i++) sample(i, (i == 4) ? 1'b1 : 1'b0);
        chk("rdrst_trig_pos", trig_pos, 3);
        tick();
        chk("rdrst_data", rd_data, pk(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rdrst_valid", rd_valid, 0);
        chk("rdrst_rd_data", rd_data, 0);
        chk("rdrst_trig_pos0", trig_pos, 0);
        chk("rdrst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during POST after one post sample, then a fresh capture
        do_arm();
        sample(1, 1'b0);
        sample(2, 1'b1);
        sample(3, 1'b0);
        chk("pstrst_pre_state", dbg_state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pstrst_state", dbg_state, 0);
        chk("pstrst_valid", rd_valid, 0);
        chk("pstrst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_arm();
        sample(7, 1'b0);
        sample(8, 1'b1);
        sample(9, 1'b0);
        sample(10, 1'b0);
        chk("rearm_trig_pos", trig_pos, 1);
        chk("rearm_wrapped", wrapped, 0);
        read_window(7, 4, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Parametrised on-chip trace buffer for the RISC core. It samples CH channels of DATA_W-bit CPU state (e.g. pc_out, ir_out, alu_result_out, memory_out) into a circular buffer while armed. It freezes POST_TRIG samples after a trigger (e.g. the instruction stop bit) and streams the captured window oldest-first over a valid/ready port. It sits beside the CPU, fed by the same nets the simulation bench probes, so traces survive into synthesis and FPGA bring-up.

## Interface
- DATA_W, 32, width of one channel
- CH, 4, number of channels captured per sample
- DEPTH, 16, buffer entries; power of two, ≥4
- POST_TRIG, 4, samples stored after the trigger sample; 0 ≤ POST_TRIG ≤ DEPTH-1

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch_data  in  CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W]
- ch_valid  in  1  sample qualifier (e.g. PcWr); one entry stored per cycle high while capturing
- arm  in  1  start capture; honoured only in IDLE
- trigger  in  1  trigger event; honoured only in ARMED and only when ch_valid=1
- rd_data  out  CH*DATA_W  readout entry
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts entry when rd_valid&&rd_ready
- rd_last  out  1  high with the final entry of the window
- trig_pos  out  $clog2(DEPTH)  readout index (0 = oldest) of the trigger sample
- wrapped  out  1  samples were overwritten before the trigger window closed
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ARMED, POST, READ.
- IDLE: arm=1 → ARMED; clears wr_ptr, count, wrapped, post_cnt.
- ARMED: each ch_valid=1 cycle writes ch_data at wr_ptr, wr_ptr++ mod DEPTH, count saturates at DEPTH. Writing when count==DEPTH sets wrapped.
- Trigger: ch_valid&&trigger in ARMED stores that sample as the trigger sample.
  - POST_TRIG=0 → READ next cycle.
  - Otherwise → POST.
- POST: stores further ch_valid samples with the same rules; after the POST_TRIG-th one → READ. Trigger is ignored in POST.
- READ:
  - Entries read oldest-first: start = (count==DEPTH) ? wr_ptr : 0, n = count.
  - trig_pos = n-1-POST_TRIG, latched on entry to READ.
  - Capture is disabled; ch_valid and trigger are ignored.
  - After the entry with rd_last is accepted → IDLE.
- arm outside IDLE is ignored; no abort except reset.
- Buffer contents are not reset; only pointers, counters and flags are.
- Pointer arithmetic is unsigned $clog2(DEPTH) bits, wrapping naturally; count is $clog2(DEPTH)+1 bits.

## Timing
- Reset values: rd_valid=0, rd_last=0, rd_data=0, trig_pos=0, wrapped=0, busy=0, state IDLE.
- arm at edge E → busy=1 after E. The first storable sample is at edge E+1.
- Sample write: stored at the edge where ch_valid=1. Trigger sample is stored in the same edge.
- READ entry at edge R → rd_valid=1 after edge R+1 (one-cycle registered memory read), rd_data = oldest entry.
- Handshake:
  - rd_data, rd_valid and rd_last are registered and held stable while rd_valid&&!rd_ready.
  - On acceptance the next entry is presented after the following edge with no bubble, so the port sustains 1 entry/cycle with rd_ready held high.
- After the last accept: rd_valid=0, rd_last=0, busy=0 after that edge.
- trig_pos and wrapped are stable from R until the next arm.
- Reset asserted in any state, including mid-POST or mid-READ, forces the reset values immediately, asynchronously.

## Test plan
(DATA_W=32, CH=2, DEPTH=8, POST_TRIG=2; channel0=i, channel1=i+100 for sample i.)
- Reset: assert rst_n=0 mid-sim → all outputs reach reset values without waiting for a clock edge; busy=0.
- Short capture: arm; samples 1,2,3 with trigger on 3; samples 4,5 → READ; readout 1..5 (ch1 101..105), rd_last on 5, trig_pos=2, wrapped=0, busy=0 after final accept.
- Wrap: arm; samples 1..12 with trigger on 10 → readout 5..12, trig_pos=5, wrapped=1.
- Backpressure: during readout hold rd_ready=0 for 3 cycles on entry 3 → rd_data=3/103 and rd_valid=1 held; release → 4 follows next cycle, order intact.
- Qualification: trigger=1 with ch_valid=0 in ARMED → no state change; trigger during POST ignored; arm during READ ignored (window unchanged).
- Reset mid-operation: rst_n low during POST after 1 post sample → IDLE, rd_valid=0. Re-arm then samples 7,8(trig),9,10 → readout 7..10 only, trig_pos=1.
